// File: rtl/map_port_arbiter.sv
// map_port_arbiter
// Shares memory port B of the maze tile RAM between NUM_RD tile readers
// (pacman and the four ghosts) and one tile writer (the cookie/candy eater).
// At most one memory operation is issued per cycle. Writes have priority but
// may only run for two cycles back to back while a read is waiting. Reads are
// granted round-robin, and each read's data is returned one cycle after its
// grant.
//
// Ports
//   vga_pix_clk  sole clock (rising edge)
//   rst          synchronous reset, active-low
//   rd_req       per-requester level read request
//   rd_addr      packed read addresses, requester i at [i*ADDR_W +: ADDR_W]
//   rd_gnt       one-hot read grant (0-latency, combinational)
//   rsp_valid    one-hot response strobe, one cycle after the grant
//   rsp_tile     response tile data (0 when no response)
//   wr_req       level write request
//   wr_addr      write address
//   wr_data      write tile value
//   wr_ack       write issued this cycle
//   addrb        memory port-B address
//   web          memory port-B write enable
//   dib          memory port-B write data
//   doutb        memory port-B read data (one cycle after addrb)
module map_port_arbiter #(
  parameter int         NUM_RD    = 5,
  parameter int         ADDR_W    = 11,
  parameter int         MAP_DEPTH = 1152,
  parameter logic [3:0] OOB_TILE  = 4'h1
) (
  input  logic                     vga_pix_clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_gnt,
  output logic [NUM_RD-1:0]        rsp_valid,
  output logic [3:0]               rsp_tile,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [3:0]               wr_data,
  output logic                     wr_ack,
  output logic [ADDR_W-1:0]        addrb,
  output logic                     web,
  output logic [3:0]               dib,
  input  logic [3:0]               doutb
);

  localparam int IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  // One extra bit so MAP_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MAP_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [1:0]         wr_cnt_q, wr_cnt_d;
  logic [IDX_W-1:0]   rsp_idx_q, rsp_idx_d;
  logic               rsp_oob_q, rsp_oob_d;
  logic [ADDR_W-1:0]  addrb_q, addrb_d;

  logic               sel_wr_s;
  logic               sel_rd_s;
  logic               found_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic               rd_oob_s;
  logic               wr_oob_s;
  int                 cand_idx_s;

  // State register: all flops, synchronous active-low reset.
  always_ff @(posedge vga_pix_clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      last_q    <= IDX_W'(NUM_RD - 1);
      wr_cnt_q  <= 2'd0;
      rsp_idx_q <= '0;
      rsp_oob_q <= 1'b0;
      addrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wr_cnt_q  <= wr_cnt_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_oob_q <= rsp_oob_d;
      addrb_q   <= addrb_d;
    end
  end

  // Next-state logic: arbitration decision and bookkeeping updates.
  always_comb begin
    found_s    = 1'b0;
    gnt_idx_s  = '0;
    cand_idx_s = 0;
    // Round-robin search starting just after the last granted requester.
    for (int k = 0; k < NUM_RD; k++) begin
      cand_idx_s = (int'(last_q) + 1 + k) % NUM_RD;
      if (!found_s && rd_req[cand_idx_s]) begin
        found_s   = 1'b1;
        gnt_idx_s = IDX_W'(cand_idx_s);
      end else begin
        found_s   = found_s;
      end
    end
    sel_addr_s = rd_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
    rd_oob_s   = ({1'b0, sel_addr_s} >= DEPTH_L);
    wr_oob_s   = ({1'b0, wr_addr} >= DEPTH_L);

    sel_wr_s = 1'b0;
    sel_rd_s = 1'b0;
    if (!rst) begin
      state_d = ST_IDLE;
    end else if (wr_req && !((wr_cnt_q == 2'd2) && (|rd_req))) begin
      // A third back-to-back write yields to any waiting reader.
      sel_wr_s = 1'b1;
      state_d  = ST_WR;
    end else if (found_s) begin
      sel_rd_s = 1'b1;
      state_d  = ST_RD;
    end else begin
      state_d  = ST_IDLE;
    end

    if (sel_wr_s) begin
      wr_cnt_d = (wr_cnt_q == 2'd2) ? 2'd2 : (wr_cnt_q + 2'd1);
    end else begin
      wr_cnt_d = 2'd0;
    end

    if (sel_rd_s) begin
      last_d    = gnt_idx_s;
      rsp_idx_d = gnt_idx_s;
      rsp_oob_d = rd_oob_s;
    end else begin
      last_d    = last_q;
      rsp_idx_d = rsp_idx_q;
      rsp_oob_d = 1'b0;
    end
  end

  // Output logic: port-B drive, grants, acks and the registered response.
  always_comb begin
    rd_gnt    = '0;
    rsp_valid = '0;
    rsp_tile  = 4'h0;
    wr_ack    = 1'b0;
    web       = 1'b0;
    dib       = 4'h0;
    addrb     = addrb_q;
    if (!rst) begin
      addrb = '0;
    end else if (sel_wr_s) begin
      wr_ack = 1'b1;
      // Out-of-range writes are acknowledged but never reach the RAM.
      if (!wr_oob_s) begin
        web   = 1'b1;
        addrb = wr_addr;
        dib   = wr_data;
      end else begin
        web   = 1'b0;
      end
    end else if (sel_rd_s) begin
      rd_gnt[gnt_idx_s] = 1'b1;
      // Out-of-range reads leave addrb untouched; the response is substituted.
      if (!rd_oob_s) begin
        addrb = sel_addr_s;
      end else begin
        addrb = addrb_q;
      end
    end else begin
      addrb = addrb_q;
    end

    case (state_q)
      ST_RD: begin
        if (rst) begin
          rsp_valid[rsp_idx_q] = 1'b1;
          rsp_tile = rsp_oob_q ? OOB_TILE : doutb;
        end else begin
          rsp_tile = 4'h0;
        end
      end
      default: begin
        rsp_tile = 4'h0;
      end
    endcase
    addrb_d = addrb;
  end

endmodule

// File: tb/tb_map_port_arbiter.sv
module tb_map_port_arbiter;

  localparam int NR = 5;
  localparam int AW = 11;
  localparam int DEPTH = 1152;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   rd_req = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR-1:0]   rd_gnt, rsp_valid;
  logic [3:0]      rsp_tile;
  logic            wr_req = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [3:0]      wr_data = 4'h0;
  logic            wr_ack;
  logic [AW-1:0]   addrb;
  logic            web;
  logic [3:0]      dib;
  logic [3:0]      doutb;

  int errors = 0;
  int checks = 0;

  map_port_arbiter dut (
    .vga_pix_clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rsp_valid(rsp_valid), .rsp_tile(rsp_tile),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .addrb(addrb), .web(web), .dib(dib), .doutb(doutb)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] tile_init(int a);
    return 4'((a * 7 + 3) % 16);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Tile RAM behind port B, write-first, one cycle read latency.
  logic [3:0] ram [0:2047];
  bit ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int a = 0; a < 2048; a++) ram[a] <= tile_init(a);
      ram_init <= 1'b1;
      doutb <= 4'h0;
    end else begin
      if (web) ram[addrb] <= dib;
      doutb <= web ? dib : ram[addrb];
    end
  end

  // Reference model: rules applied directly to inputs each cycle.
  logic [3:0]    mmem [0:2047];
  int            m_last, m_wcnt, m_pidx, win, a;
  bit            m_pend, do_wr;
  logic [3:0]    m_ptile;
  logic [AW-1:0] m_hold;
  logic [NR-1:0] e_gnt, e_rv;
  logic [3:0]    e_tile, e_dib;
  logic          e_ack, e_web;
  logic [AW-1:0] e_addrb;

  initial begin
    for (int i = 0; i < 2048; i++) mmem[i] = tile_init(i);
    m_last = NR - 1; m_wcnt = 0; m_pend = 1'b0; m_hold = '0;
    m_pidx = 0; m_ptile = 4'h0;
    forever begin
      @(negedge clk);
      e_gnt = '0; e_rv = '0; e_tile = 4'h0; e_dib = 4'h0;
      e_ack = 1'b0; e_web = 1'b0; e_addrb = '0;
      if (!rst) begin
        m_last = NR - 1; m_wcnt = 0; m_pend = 1'b0; m_hold = '0;
      end else begin
        e_addrb = m_hold;
        if (m_pend) begin
          e_rv[m_pidx] = 1'b1;
          e_tile = m_ptile;
        end
        m_pend = 1'b0;
        do_wr = wr_req && !(m_wcnt >= 2 && rd_req != '0);
        win = -1;
        if (do_wr) begin
          e_ack = 1'b1;
          if (int'(wr_addr) < DEPTH) begin
            e_web = 1'b1; e_addrb = wr_addr; e_dib = wr_data;
            mmem[wr_addr] = wr_data;
          end
          m_wcnt = (m_wcnt >= 2) ? 2 : m_wcnt + 1;
        end else begin
          m_wcnt = 0;
          for (int k = 1; k <= NR; k++)
            if (win < 0 && rd_req[(m_last + k) % NR]) win = (m_last + k) % NR;
        end
        if (win >= 0) begin
          e_gnt[win] = 1'b1;
          a = int'(rd_addr[win*AW +: AW]);
          if (a < DEPTH) begin
            e_addrb = AW'(a);
            m_ptile = mmem[a];
          end else begin
            m_ptile = 4'h1;
          end
          m_pend = 1'b1; m_pidx = win; m_last = win;
        end
        m_hold = e_addrb;
      end
      chk("m_rd_gnt", 32'(rd_gnt), 32'(e_gnt));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("m_rsp_tile", 32'(rsp_tile), 32'(e_tile));
      chk("m_wr_ack", 32'(wr_ack), 32'(e_ack));
      chk("m_web", 32'(web), 32'(e_web));
      chk("m_addrb", 32'(addrb), 32'(e_addrb));
      chk("m_dib", 32'(dib), 32'(e_dib));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(int i, int v);
    rd_addr[i*AW +: AW] = AW'(v);
  endtask

  logic [3:0] web_seq [0:4];

  initial begin
    web_seq[0] = 4'd1; web_seq[1] = 4'd1; web_seq[2] = 4'd0;
    web_seq[3] = 4'd1; web_seq[4] = 4'd1;

    // Reset: requests ignored, outputs quiet.
    rst = 1'b0; rd_req = 5'b11111; wr_req = 1'b1; wr_addr = 11'd5;
    repeat (3) cyc();
    #2;
    chk("rst_gnt", 32'(rd_gnt), 32'h0);
    chk("rst_web", 32'(web), 32'h0);
    chk("rst_ack", 32'(wr_ack), 32'h0);
    chk("rst_addrb", 32'(addrb), 32'h0);
    cyc();

    // Scenario 1: all five requesting, strict rotation from requester 0.
    wr_req = 1'b0;
    for (int i = 0; i < NR; i++) set_addr(i, 10 + i);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #2;
      chk("s1_gnt", 32'(rd_gnt), 32'(1 << (c % 5)));
      if (c > 0) begin
        chk("s1_rv", 32'(rsp_valid), 32'(1 << ((c - 1) % 5)));
        chk("s1_tile", 32'(rsp_tile), 32'(tile_init(10 + (c - 1) % 5)));
      end
      cyc();
    end
    rd_req = '0;
    #2;
    chk("s1_last_rv", 32'(rsp_valid), 32'h10);
    cyc();

    // Scenario 2: write to 33 then read 33 returns the new value.
    wr_req = 1'b1; wr_addr = 11'd33; wr_data = 4'h0;
    rd_req = 5'b00001; set_addr(0, 33);
    #2;
    chk("s2_web", 32'(web), 32'h1);
    chk("s2_ack", 32'(wr_ack), 32'h1);
    chk("s2_gnt0", 32'(rd_gnt), 32'h0);
    cyc();
    wr_req = 1'b0;
    #2;
    chk("s2_gnt1", 32'(rd_gnt), 32'h1);
    chk("s2_addrb", 32'(addrb), 32'd33);
    cyc();
    rd_req = '0;
    #2;
    chk("s2_rv", 32'(rsp_valid), 32'h1);
    chk("s2_tile", 32'(rsp_tile), 32'h0);
    cyc();

    // Scenario 3: held write gives way to a waiting read after two writes.
    wr_req = 1'b1; wr_addr = 11'd40; wr_data = 4'h3;
    rd_req = 5'b00100; set_addr(2, 50);
    for (int c = 0; c < 5; c++) begin
      #2;
      chk("s3_web", 32'(web), 32'(web_seq[c]));
      chk("s3_gnt", 32'(rd_gnt), (c == 2) ? 32'h4 : 32'h0);
      cyc();
      if (c == 2) rd_req = '0;
    end
    wr_req = 1'b0;
    cyc();

    // Scenario 4: out-of-range read, addrb keeps the last write address.
    rd_req = 5'b00010; set_addr(1, 1200);
    #2;
    chk("s4_gnt", 32'(rd_gnt), 32'h2);
    chk("s4_addrb", 32'(addrb), 32'd40);
    cyc();
    rd_req = '0;
    #2;
    chk("s4_rv", 32'(rsp_valid), 32'h2);
    chk("s4_tile", 32'(rsp_tile), 32'h1);
    chk("s4_addrb2", 32'(addrb), 32'd40);
    cyc();

    // Scenario 5: reset right after a grant drops the response.
    rd_req = 5'b01000; set_addr(3, 7);
    #2;
    chk("s5_gnt", 32'(rd_gnt), 32'h8);
    cyc();
    rst = 1'b0; rd_req = '0;
    #2;
    chk("s5_rv_rst", 32'(rsp_valid), 32'h0);
    cyc();
    rst = 1'b1; rd_req = 5'b01000;
    #2;
    chk("s5_rv_after", 32'(rsp_valid), 32'h0);
    chk("s5_gnt3", 32'(rd_gnt), 32'h8);
    cyc();
    rst = 1'b0; rd_req = '0;
    cyc();
    rst = 1'b1; rd_req = 5'b11111;
    #2;
    chk("s5_gnt0", 32'(rd_gnt), 32'h1);
    cyc();

    // Scenario 6: random traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      rd_req  = NR'($urandom_range(0, 31));
      for (int i = 0; i < NR; i++) set_addr(i, $urandom_range(0, 1299));
      wr_req  = ($urandom_range(0, 9) < 4);
      wr_addr = AW'($urandom_range(0, 1299));
      wr_data = 4'($urandom_range(0, 15));
      cyc();
    end
    rd_req = '0; wr_req = 1'b0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
